logic_accumulator: RTL and testbench
====================================

LOGIC_ACCUMULATOR -- requirements
Module: logic_accumulator

Interface
REQ-001 Parameter: WIDTH, default 32, data path width of operand, accumulator and result.
REQ-002 Port: clock  input  1  single clock, all state updates on rising edge.
REQ-003 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 Port: in_valid  input  1  command/operand presented.
REQ-005 Port: in_ready  output  1  block accepts command this cycle.
REQ-006 Port: in_cmd  input  2  00 LOAD, 01 APPLY, 10 FLUSH, 11 CLEAR.
REQ-007 Port: in_op  input  2  logic op for APPLY: 00 AND, 01 OR, 10 NOR, 11 XOR.
REQ-008 Port: in_data  input  WIDTH  operand.
REQ-009 Port: out_valid  output  1  flushed result available.
REQ-010 Port: out_ready  input  1  consumer accepts result.
REQ-011 Port: out_data  output  WIDTH  flushed accumulator value.
REQ-012 Port: out_count  output  8  number of APPLY ops folded into out_data.
REQ-013 Port: out_zero  output  1  out_data equals zero.

Function
REQ-014 Two states, IDLE and EMIT; in_ready SHALL be 1 exactly in IDLE, and out_valid SHALL be 1 exactly in EMIT.
REQ-015 Command accepted on a clock edge where in_valid and in_ready are both 1; no other edge changes acc or count.
REQ-016 LOAD: acc <= in_data; count <= 0; stay IDLE.
REQ-017 APPLY: acc <= acc OP in_data (bitwise, per in_op); count <= count+1, saturating at 255; stay IDLE.
REQ-018 NOR is bitwise ~(acc | in_data) across all WIDTH bits.
REQ-019 FLUSH: out_data <= acc, out_count <= count, out_zero <= (acc==0); acc <= 0; count <= 0; next state EMIT.
REQ-020 CLEAR: acc <= 0; count <= 0; stay IDLE; outputs unchanged.
REQ-021 Result of an APPLY is visible to the next accepted command (one-cycle latency, back-to-back APPLY at full rate).
REQ-022 FLUSH-to-out_valid latency: out_valid high in the cycle after FLUSH acceptance.
REQ-023 EMIT: out_data/out_count/out_zero held stable while out_valid=1 and out_ready=0.
REQ-024 EMIT with out_ready=1 on an edge: return to IDLE; out_valid low next cycle.
REQ-025 out_ready ignored in IDLE; in_valid ignored (no state change) in EMIT.
REQ-026 out_data, out_count, out_zero retain last flushed values in IDLE.
REQ-027 Count saturation: APPLY at count=255 leaves count at 255 while still updating acc.

Reset
REQ-028 reset_n low SHALL immediately force state=IDLE, acc=0, count=0, out_data=0, out_count=0, out_zero=1, out_valid=0, in_ready=1.
REQ-029 Reset asserted in EMIT discards the pending result; no handshake completes.
REQ-030 First command accepted on the first rising edge after reset_n deasserts with in_valid=1.

Structure
REQ-031 Shared package holds command encodings (LOAD/APPLY/FLUSH/CLEAR), op encodings (AND/OR/NOR/XOR) and state encoding.
REQ-032 The combinational op SHALL be a single sub-module instance, logicunit (out, A=acc, B=in_data, control=in_op), widened to WIDTH.
REQ-033 Accumulator, counter, output registers and FSM live in logic_accumulator; no further sub-modules.

Verification
REQ-034 Reset: reset_n=0 mid-EMIT -> out_valid=0, in_ready=1, out_zero=1, out_data=0 immediately (before next edge).
REQ-035 Op sweep (WIDTH=32): LOAD 0xF0F0F0F0, APPLY AND 0xFF00FF00, FLUSH -> out_data=0xF000F000, out_count=1; repeat with OR -> 0xFFF0FFF0, NOR -> 0x000F000F, XOR -> 0x0FF00FF0.
REQ-036 Backpressure: FLUSH with out_ready=0 for 5 cycles -> out_valid stays 1, in_ready stays 0, outputs stable; out_ready=1 -> IDLE next cycle.
REQ-037 Back-to-back: LOAD 0, then APPLY OR 0x1, 0x2, 0x4, 0x8 on consecutive cycles, FLUSH -> out_data=0xF, out_count=4, out_zero=0.
REQ-038 Saturation/zero: LOAD 0, 300 APPLY AND 0xFFFFFFFF, FLUSH -> out_count=255, out_data=0, out_zero=1; next FLUSH without ops -> out_count=0, out_data=0.
REQ-039 CLEAR/ignore: LOAD 0x1234, CLEAR, FLUSH -> out_data=0; in_valid pulses during EMIT -> no change to acc or count.

Source files
------------

// File: rtl/logic_accumulator_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : logic_accumulator_pkg
//  Description : Shared encodings for the logic accumulator: command codes,
//                bitwise operation codes, FSM state encoding and counter
//                constants.
//  Revision    : 1.0 - initial release
// ============================================================================
package logic_accumulator_pkg;

    // Command presented on in_cmd
    typedef enum logic [1:0] {
        CMD_LOAD  = 2'b00,
        CMD_APPLY = 2'b01,
        CMD_FLUSH = 2'b10,
        CMD_CLEAR = 2'b11
    } cmd_e;

    // Bitwise operation selected on in_op for APPLY
    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_NOR = 2'b10,
        OP_XOR = 2'b11
    } op_e;

    // Controller state; EMIT holds a flushed result for the consumer
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_e;

    localparam int unsigned c_COUNT_W   = 8;
    localparam logic [7:0]  c_COUNT_MAX = 8'hFF;

endpackage : logic_accumulator_pkg
`default_nettype wire

// File: rtl/logic_accumulator_logicunit.sv
`default_nettype none
// ============================================================================
//  Module      : logicunit
//  Description : Purely combinational WIDTH-bit bitwise unit.
//                out = A <op> B, op chosen by control (AND/OR/NOR/XOR).
//  Ports       : out     - result            (WIDTH)
//                A       - first operand     (WIDTH)
//                B       - second operand    (WIDTH)
//                control - operation select  (2)
//  Revision    : 1.0 - initial release
// ============================================================================
module logicunit
    import logic_accumulator_pkg::*;
#(
    parameter int WIDTH = 32
) (
    output logic [WIDTH-1:0] out,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [1:0]       control
);

    always_comb begin
        out = '0;
        case (control)
            OP_AND: out = A & B;
            OP_OR:  out = A | B;
            OP_NOR: out = ~(A | B);
            OP_XOR: out = A ^ B;
        endcase
    end

endmodule : logicunit
`default_nettype wire

// File: rtl/logic_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : logic_accumulator
//  Description : Command-driven bitwise accumulator. LOAD seeds the
//                accumulator, APPLY folds in an operand with AND/OR/NOR/XOR
//                and counts the fold (saturating at 255), FLUSH hands the
//                accumulator and count to the output side and clears them,
//                CLEAR zeroes them without touching the outputs.
//  Ports       : clock, reset_n          - clock / async active-low reset
//                in_valid/in_ready       - command handshake
//                in_cmd, in_op, in_data  - command, APPLY op, operand
//                out_valid/out_ready     - result handshake
//                out_data, out_count     - flushed value and APPLY count
//                out_zero                - flushed value equals zero
//  Revision    : 1.0 - initial release
// ============================================================================
module logic_accumulator
    import logic_accumulator_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_cmd,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [7:0]       out_count,
    output logic             out_zero
);

    state_e                 r_state;
    logic [WIDTH-1:0]       r_acc;
    logic [c_COUNT_W-1:0]   r_count;
    logic [WIDTH-1:0]       r_out_data;
    logic [c_COUNT_W-1:0]   r_out_count;
    logic                   r_out_zero;

    logic [WIDTH-1:0]       w_apply_result;
    logic [c_COUNT_W-1:0]   w_count_inc;

    logicunit #(
        .WIDTH   (WIDTH)
    ) u_logicunit (
        .out     (w_apply_result),
        .A       (r_acc),
        .B       (in_data),
        .control (in_op)
    );

    // Count holds at its maximum so a long fold never wraps back to zero
    assign w_count_inc = (r_count == c_COUNT_MAX) ? r_count : r_count + 8'd1;

    // Handshake outputs decode directly from the state register, so they are
    // glitch-free and follow the asynchronous reset immediately.
    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_EMIT);
    assign out_data  = r_out_data;
    assign out_count = r_out_count;
    assign out_zero  = r_out_zero;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_acc       <= '0;
            r_count     <= '0;
            r_out_data  <= '0;
            r_out_count <= '0;
            r_out_zero  <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        case (in_cmd)
                            CMD_LOAD: begin
                                r_acc   <= in_data;
                                r_count <= '0;
                            end
                            CMD_APPLY: begin
                                r_acc   <= w_apply_result;
                                r_count <= w_count_inc;
                            end
                            CMD_FLUSH: begin
                                r_out_data  <= r_acc;
                                r_out_count <= r_count;
                                r_out_zero  <= (r_acc == '0);
                                r_acc       <= '0;
                                r_count     <= '0;
                                r_state     <= ST_EMIT;
                            end
                            CMD_CLEAR: begin
                                r_acc   <= '0;
                                r_count <= '0;
                            end
                        endcase
                    end
                end
                ST_EMIT: begin
                    // Commands are not accepted here; only the consumer
                    // handshake moves the controller back to IDLE.
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule : logic_accumulator
`default_nettype wire

// File: tb/tb_logic_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_logic_accumulator
//  Description : Self-checking bench for logic_accumulator (WIDTH=32).
//                A behavioural model tracks acc/count as commands are driven;
//                each FLUSH pushes the expected result to a scoreboard queue
//                which is popped when the result handshake completes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_logic_accumulator;

    localparam logic [1:0] LOAD  = 2'b00;
    localparam logic [1:0] APPLY = 2'b01;
    localparam logic [1:0] FLUSH = 2'b10;
    localparam logic [1:0] CLEAR = 2'b11;
    localparam logic [1:0] AND_  = 2'b00;
    localparam logic [1:0] OR_   = 2'b01;
    localparam logic [1:0] NOR_  = 2'b10;
    localparam logic [1:0] XOR_  = 2'b11;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_cmd;
    logic [1:0]  in_op;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [7:0]  out_count;
    logic        out_zero;

    logic_accumulator #(
        .WIDTH     (32)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_cmd    (in_cmd),
        .in_op     (in_op),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .out_zero  (out_zero)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] data;
        logic [7:0]  count;
        logic        zero;
    } result_t;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] operand;
        logic [31:0] exp_data;
    } vec_t;

    result_t     sb[$];
    vec_t        vecs[4];
    logic [31:0] m_acc;
    logic [7:0]  m_cnt;
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [31:0] model_op(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
        case (op)
            AND_:    return a & b;
            OR_:     return a | b;
            NOR_:    return ~(a | b);
            default: return a ^ b;
        endcase
    endfunction

    // Drive one command at a negedge so it is accepted at the next posedge.
    task automatic send(input logic [1:0] cmd, input logic [1:0] op, input logic [31:0] data);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (!in_ready) begin
            check("send_ready_timeout", {63'd0, in_ready}, 64'd1);
            return;
        end
        in_valid = 1'b1;
        in_cmd   = cmd;
        in_op    = op;
        in_data  = data;
        case (cmd)
            LOAD: begin m_acc = data; m_cnt = 8'd0; end
            APPLY: begin
                m_acc = model_op(op, m_acc, data);
                if (m_cnt != 8'd255) m_cnt = m_cnt + 8'd1;
            end
            FLUSH: begin
                sb.push_back('{data: m_acc, count: m_cnt, zero: (m_acc == 32'd0)});
                m_acc = 32'd0;
                m_cnt = 8'd0;
            end
            default: begin m_acc = 32'd0; m_cnt = 8'd0; end
        endcase
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic flush();
        send(FLUSH, 2'b00, 32'd0);
        check("flush_latency_valid", {63'd0, out_valid}, 64'd1);
        check("flush_latency_ready", {63'd0, in_ready}, 64'd0);
    endtask

    // Accept the pending result and compare it with the scoreboard head.
    task automatic drain(output logic [31:0] got_data, output logic [7:0] got_cnt);
        result_t exp;
        int n = 0;
        got_data  = 'x;
        got_cnt   = 'x;
        out_ready = 1'b1;
        while (!out_valid && n < 50) begin
            @(negedge clock);
            n++;
        end
        check("out_valid_wait", {63'd0, out_valid}, 64'd1);
        if (out_valid) begin
            got_data = out_data;
            got_cnt  = out_count;
            if (sb.size() == 0) begin
                check("sb_nonempty", 64'd0, 64'd1);
            end else begin
                exp = sb.pop_front();
                check("sb_data",  {32'd0, out_data},  {32'd0, exp.data});
                check("sb_count", {56'd0, out_count}, {56'd0, exp.count});
                check("sb_zero",  {63'd0, out_zero},  {63'd0, exp.zero});
            end
        end
        @(negedge clock);
        out_ready = 1'b0;
        check("emit_release_valid", {63'd0, out_valid}, 64'd0);
        check("emit_release_ready", {63'd0, in_ready}, 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] gd, d0;
        logic [7:0]  gc, c0;

        vecs[0] = '{op: AND_, operand: 32'hFF00FF00, exp_data: 32'hF000F000};
        vecs[1] = '{op: OR_,  operand: 32'hFF00FF00, exp_data: 32'hFFF0FFF0};
        vecs[2] = '{op: NOR_, operand: 32'hFF00FF00, exp_data: 32'h000F000F};
        vecs[3] = '{op: XOR_, operand: 32'hFF00FF00, exp_data: 32'h0FF00FF0};

        m_acc     = 32'd0;
        m_cnt     = 8'd0;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_cmd    = LOAD;
        in_op     = AND_;
        in_data   = 32'd0;
        out_ready = 1'b0;

        repeat (3) @(negedge clock);
        check("rst_in_ready",  {63'd0, in_ready},  64'd1);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_zero",  {63'd0, out_zero},  64'd1);
        check("rst_out_data",  {32'd0, out_data},  64'd0);
        check("rst_out_count", {56'd0, out_count}, 64'd0);
        reset_n = 1'b1;

        // Op sweep
        for (int i = 0; i < 4; i++) begin
            send(LOAD, AND_, 32'hF0F0F0F0);
            send(APPLY, vecs[i].op, vecs[i].operand);
            flush();
            drain(gd, gc);
            check("sweep_data",  {32'd0, gd}, {32'd0, vecs[i].exp_data});
            check("sweep_count", {56'd0, gc}, 64'd1);
        end

        // Back-to-back APPLY at full rate
        send(LOAD, AND_, 32'd0);
        send(APPLY, OR_, 32'h1);
        send(APPLY, OR_, 32'h2);
        send(APPLY, OR_, 32'h4);
        send(APPLY, OR_, 32'h8);
        flush();
        check("b2b_zero_flag", {63'd0, out_zero}, 64'd0);
        drain(gd, gc);
        check("b2b_data",  {32'd0, gd}, 64'hF);
        check("b2b_count", {56'd0, gc}, 64'd4);

        // Backpressure with commands offered during EMIT
        send(LOAD, AND_, 32'hA5A5_0001);
        send(APPLY, XOR_, 32'h0000_FFFF);
        flush();
        d0 = out_data;
        c0 = out_count;
        for (int k = 0; k < 5; k++) begin
            if (k == 2) begin
                in_valid = 1'b1;
                in_cmd   = LOAD;
                in_data  = 32'hDEADBEEF;
                out_ready = 1'b0;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clock);
            check("bp_out_valid", {63'd0, out_valid}, 64'd1);
            check("bp_in_ready",  {63'd0, in_ready},  64'd0);
            check("bp_data_hold", {32'd0, out_data},  {32'd0, d0});
            check("bp_cnt_hold",  {56'd0, out_count}, {56'd0, c0});
        end
        in_valid = 1'b0;
        drain(gd, gc);
        check("bp_data", {32'd0, gd}, 64'hA5A5_FFFE);
        // The LOAD offered during EMIT must not have reached acc
        flush();
        drain(gd, gc);
        check("emit_ignore_data", {32'd0, gd}, 64'd0);

        // Saturation and zero flag
        send(LOAD, AND_, 32'd0);
        for (int k = 0; k < 300; k++) send(APPLY, AND_, 32'hFFFFFFFF);
        flush();
        check("sat_zero_flag", {63'd0, out_zero}, 64'd1);
        drain(gd, gc);
        check("sat_count", {56'd0, gc}, 64'd255);
        check("sat_data",  {32'd0, gd}, 64'd0);
        flush();
        drain(gd, gc);
        check("post_flush_count", {56'd0, gc}, 64'd0);
        check("post_flush_data",  {32'd0, gd}, 64'd0);

        // CLEAR
        send(LOAD, AND_, 32'h1234);
        send(CLEAR, AND_, 32'd0);
        check("clear_keeps_out", {32'd0, out_data}, 64'd0);
        flush();
        drain(gd, gc);
        check("clear_data", {32'd0, gd}, 64'd0);

        // Reset in EMIT discards the result, asynchronously
        send(LOAD, AND_, 32'h55);
        flush();
        #2 reset_n = 1'b0;
        #1;
        check("arst_out_valid", {63'd0, out_valid}, 64'd0);
        check("arst_in_ready",  {63'd0, in_ready},  64'd1);
        check("arst_out_zero",  {63'd0, out_zero},  64'd1);
        check("arst_out_data",  {32'd0, out_data},  64'd0);
        sb.delete();
        m_acc = 32'd0;
        m_cnt = 8'd0;
        @(negedge clock);
        reset_n = 1'b1;
        // First command on the first edge after release
        send(LOAD, AND_, 32'h77);
        flush();
        drain(gd, gc);
        check("post_rst_data",  {32'd0, gd}, 64'h77);
        check("post_rst_count", {56'd0, gc}, 64'd0);
        check("sb_empty", {32'd0, 32'(sb.size())}, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_logic_accumulator
`default_nettype wire
